// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg -- shared types and constants for the PS/2 receiver slice.
//
// Contents:
//   state_t            receiver FSM state encoding (IDLE, DPS, LOAD)
//   DATA_W             width of one received byte
//   FRAME_SHIFT_BITS   bits shifted in after the start bit (8 data, parity, stop)
//   PS2_PARITY_ODD     required XOR over data + parity bit (odd parity)
//   odd_parity_ok()    parity check helper used when parity checking is built
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DPS,
        LOAD
    } state_t;

    localparam int   DATA_W           = 8;
    localparam int   FRAME_SHIFT_BITS = 10;
    localparam logic PS2_PARITY_ODD   = 1'b1;

    // True when the data byte plus its parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_W-1:0] data,
                                           input logic              par);
        return ((^data) ^ par) == PS2_PARITY_ODD;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ---------------------------------------------------------------------------
// ps2_clk_filter -- line conditioning for the PS/2 receiver.
//
// Both raw lines are brought into the clk domain through 2-FF synchronisers.
// The synchronised clock line then runs through a FILTER_LEN-deep shift
// register; the filtered level only changes once every stage agrees, so
// pulses shorter than FILTER_LEN cycles are rejected. A falling edge of the
// filtered level produces a one-cycle 'fall' pulse.
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous reset, active-low
//   ps2c    in   raw PS/2 clock line (asynchronous)
//   ps2d    in   raw PS/2 data line (asynchronous)
//   fall    out  one-cycle pulse on a filtered ps2c falling edge
//   ps2d_s  out  synchronised ps2d, valid to sample while fall is high
// ---------------------------------------------------------------------------
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic fall,
    output logic ps2d_s
);

    logic                  c_meta, c_sync;
    logic                  d_meta, d_sync;
    logic [FILTER_LEN-1:0] filt_sreg;
    logic [FILTER_LEN-1:0] filt_sreg_next;
    logic                  filt;
    logic                  filt_prev;

    assign filt_sreg_next = {filt_sreg[FILTER_LEN-2:0], c_sync};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others; blocking here would collapse the
    // synchroniser chain into a single stage.
    // NOTE: the synchronisers and filter reset to 1 (the idle level of an
    // open-collector PS/2 line) so releasing reset never fakes a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_meta    <= 1'b1;
            c_sync    <= 1'b1;
            d_meta    <= 1'b1;
            d_sync    <= 1'b1;
            filt_sreg <= '1;
            filt      <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            c_meta    <= ps2c;
            c_sync    <= c_meta;
            d_meta    <= ps2d;
            d_sync    <= d_meta;
            filt_sreg <= filt_sreg_next;
            // Decide on the incoming window so the level moves in the same
            // cycle the window becomes uniform; mixed windows hold the level.
            if (&filt_sreg_next) begin
                filt <= 1'b1;
            end else if (~|filt_sreg_next) begin
                filt <= 1'b0;
            end
            filt_prev <= filt;
        end
    end

    assign fall   = filt_prev & ~filt;
    assign ps2d_s = d_sync;

endmodule

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx -- PS/2 device-to-host receiver.
//
// Deserialises 11-bit PS/2 frames (start, 8 data bits LSB first, odd parity,
// stop) and presents each good byte on dout together with a one-cycle
// rx_done_tick. Bad frames (start bit 1, stop bit 0, inter-bit timeout, and
// optionally parity) produce a one-cycle frame_err instead and leave dout
// untouched. dout/rx_done_tick feed the downstream packet buffer's d/tick.
//
// Build option:
//   PS2_RX_PARITY_EN  when defined, odd parity is checked in addition to the
//                     stop bit; otherwise the parity bit is received and
//                     ignored.
//
// Parameters:
//   FILTER_LEN   consecutive equal ps2c samples needed to change level (2..16)
//   TIMEOUT_CYC  clk cycles allowed between falling edges inside a frame
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous reset, active-low
//   rx_en         in   receive enable, only gates start-bit recognition
//   ps2c          in   raw PS/2 clock line
//   ps2d          in   raw PS/2 data line
//   dout          out  last correctly received byte
//   rx_done_tick  out  one-cycle pulse, dout holds a new byte
//   frame_err     out  one-cycle pulse, a frame was discarded
// ---------------------------------------------------------------------------
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_en,
    input  logic              ps2c,
    input  logic              ps2d,
    output logic [DATA_W-1:0] dout,
    output logic              rx_done_tick,
    output logic              frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    logic                          fall;
    logic                          ps2d_s;
    state_t                        state;
    // Only the first nine shifted bits need storing: the tenth (stop) bit is
    // taken straight from the line in the cycle its fall is seen.
    logic [FRAME_SHIFT_BITS-2:0]   shreg;
    logic [FRAME_SHIFT_BITS-1:0]   frame;
    logic [3:0]                    bit_cnt;
    logic [TW-1:0]                 tmo_cnt;
    logic                          frame_ok;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk    (clk),
        .reset  (reset),
        .ps2c   (ps2c),
        .ps2d   (ps2d),
        .fall   (fall),
        .ps2d_s (ps2d_s)
    );

    // Shift register contents after shifting the current data sample into
    // the MSB: {stop, parity, data[7:0]} once the tenth bit arrives.
    assign frame = {ps2d_s, shreg};

`ifdef PS2_RX_PARITY_EN
    assign frame_ok = frame[FRAME_SHIFT_BITS-1] &
                      odd_parity_ok(frame[DATA_W-1:0], frame[DATA_W]);
`else
    assign frame_ok = frame[FRAME_SHIFT_BITS-1];
`endif

    // The frame verdict is registered on the stop-bit fall so that dout and
    // rx_done_tick/frame_err become visible together during the LOAD cycle,
    // one clk after the fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            tmo_cnt      <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fall && rx_en) begin
                        if (!ps2d_s) begin
                            bit_cnt <= 4'(FRAME_SHIFT_BITS);
                            tmo_cnt <= '0;
                            state   <= DPS;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                DPS: begin
                    if (fall) begin
                        shreg   <= frame[FRAME_SHIFT_BITS-1:1];
                        bit_cnt <= bit_cnt - 4'd1;
                        tmo_cnt <= '0;
                        if (bit_cnt == 4'd1) begin
                            state <= LOAD;
                            if (frame_ok) begin
                                dout         <= frame[DATA_W-1:0];
                                rx_done_tick <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx -- directed self-checking bench for ps2_rx.
// Drives PS/2 frames bit by bit (half-period 40 clk), monitors the strobes
// on every falling clk edge and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ps2_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 200;
    localparam int HALF        = 40;
    // Driven ps2c edge -> visible strobe: 2 sync + FILTER_LEN filter + 1 FSM.
    localparam int LAT         = 2 + FILTER_LEN + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_en;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tick_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int last_tick_cyc = 0;
    int last_err_cyc = 0;
    int fall_cyc = 0;
    logic [7:0] rx_q[$];

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_en        (rx_en),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            tick_cnt      <= tick_cnt + 1;
            last_tick_cyc <= cyc;
            rx_q.push_back(dout);
        end
        if (frame_err === 1'b1) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc;
        end
        if (rx_done_tick === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first nbits of an LSB-first bit vector; rx_en drops before
    // bit index en_off_at (negative: never).
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int en_off_at);
        for (int i = 0; i < nbits; i++) begin
            if (i == en_off_at) rx_en = 1'b0;
            ps2d = bits[i];
            wait_clk(HALF);
            ps2c     = 1'b0;
            fall_cyc = cyc;
            wait_clk(HALF);
            ps2c = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_flip,
                              input logic stop, input int en_off_at);
        logic [10:0] bits;
        bits = {stop, (~^data) ^ par_flip, data, 1'b0};
        send_bits(bits, 11, en_off_at);
        ps2d = 1'b1;
    endtask

    task automatic test_reset;
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
        checks++;
        if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", rx_done_tick); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        checks++;
    endtask

    task automatic test_single;
        int t0, e0;
        t0 = tick_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        wait_clk(30);
        checks++;
        if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL single_ticks: got %0d expected 1", tick_cnt - t0); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL single_err: got %0d expected 0", err_cnt - e0); end
        checks++;
        if (dout !== 8'h1C) begin errors++; $display("FAIL single_dout: got %h expected 1c", dout); end
        checks++;
        if (last_tick_cyc !== fall_cyc + LAT) begin
            errors++; $display("FAIL single_latency: got %0d expected %0d", last_tick_cyc - fall_cyc, LAT);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b[4];
        int t0, e0, q0;
        exp_b = '{8'hF0, 8'h1C, 8'hE0, 8'h75};
        t0 = tick_cnt; e0 = err_cnt; q0 = rx_q.size();
        for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b0, 1'b1, -1);
        wait_clk(30);
        checks++;
        if (tick_cnt - t0 !== 4) begin errors++; $display("FAIL b2b_ticks: got %0d expected 4", tick_cnt - t0); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_err: got %0d expected 0", err_cnt - e0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_q.size() < q0 + i + 1) begin
                errors++; $display("FAIL b2b_byte%0d: missing, expected %h", i, exp_b[i]);
            end else if (rx_q[q0+i] !== exp_b[i]) begin
                errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[q0+i], exp_b[i]);
            end
        end
    endtask

    task automatic test_glitch;
        int t0, e0;
        // Short low pulse with data low: accepting it as a start bit would
        // misalign the following frame.
        t0 = tick_cnt; e0 = err_cnt;
        ps2d = 1'b0;
        ps2c = 1'b0; wait_clk(3); ps2c = 1'b1;
        wait_clk(30);
        ps2d = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, -1);
        wait_clk(30);
        checks++;
        if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL glitch_ticks: got %0d expected 1", tick_cnt - t0); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_err: got %0d expected 0", err_cnt - e0); end
        checks++;
        if (dout !== 8'h5A) begin errors++; $display("FAIL glitch_dout: got %h expected 5a", dout); end
        // 9-cycle pulse with data high: a recognised fall gives a bad start bit.
        t0 = tick_cnt; e0 = err_cnt;
        ps2c = 1'b0; wait_clk(9); ps2c = 1'b1;
        wait_clk(30);
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL pulse9_err: got %0d expected 1", err_cnt - e0); end
        checks++;
        if (tick_cnt - t0 !== 0) begin errors++; $display("FAIL pulse9_ticks: got %0d expected 0", tick_cnt - t0); end
    endtask

    task automatic test_bad_stop;
        int t0, e0;
        t0 = tick_cnt; e0 = err_cnt;
        send_frame(8'h55, 1'b0, 1'b0, -1);
        wait_clk(30);
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL stop_err: got %0d expected 1", err_cnt - e0); end
        checks++;
        if (tick_cnt - t0 !== 0) begin errors++; $display("FAIL stop_ticks: got %0d expected 0", tick_cnt - t0); end
        checks++;
        if (dout !== 8'h5A) begin errors++; $display("FAIL stop_dout: got %h expected 5a", dout); end
    endtask

    task automatic test_parity;
        int t0, e0;
        t0 = tick_cnt; e0 = err_cnt;
        send_frame(8'h55, 1'b1, 1'b1, -1);
        wait_clk(30);
`ifdef PS2_RX_PARITY_EN
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL parity_err: got %0d expected 1", err_cnt - e0); end
        checks++;
        if (tick_cnt - t0 !== 0) begin errors++; $display("FAIL parity_ticks: got %0d expected 0", tick_cnt - t0); end
        checks++;
        if (dout !== 8'h5A) begin errors++; $display("FAIL parity_dout: got %h expected 5a", dout); end
`else
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL parity_err: got %0d expected 0", err_cnt - e0); end
        checks++;
        if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL parity_ticks: got %0d expected 1", tick_cnt - t0); end
        checks++;
        if (dout !== 8'h55) begin errors++; $display("FAIL parity_dout: got %h expected 55", dout); end
`endif
    endtask

    task automatic test_timeout;
        int t0, e0;
        int f_last;
        logic [10:0] bits;
        t0 = tick_cnt; e0 = err_cnt;
        bits = {1'b1, ~^8'hA3, 8'hA3, 1'b0};
        send_bits(bits, 5, -1);       // start + 4 data bits, then silence
        f_last = fall_cyc;
        ps2d = 1'b1;
        wait_clk(TIMEOUT_CYC + 60);
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err: got %0d expected 1", err_cnt - e0); end
        checks++;
        if (last_err_cyc !== f_last + LAT + TIMEOUT_CYC) begin
            errors++; $display("FAIL timeout_cycle: got %0d expected %0d", last_err_cyc - f_last, LAT + TIMEOUT_CYC);
        end
        checks++;
        if (tick_cnt - t0 !== 0) begin errors++; $display("FAIL timeout_ticks: got %0d expected 0", tick_cnt - t0); end
        t0 = tick_cnt; e0 = err_cnt;
        send_frame(8'hA3, 1'b0, 1'b1, -1);
        wait_clk(30);
        checks++;
        if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL after_tmo_ticks: got %0d expected 1", tick_cnt - t0); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL after_tmo_err: got %0d expected 0", err_cnt - e0); end
        checks++;
        if (dout !== 8'hA3) begin errors++; $display("FAIL after_tmo_dout: got %h expected a3", dout); end
    endtask

    task automatic test_rx_en;
        int t0, e0;
        t0 = tick_cnt; e0 = err_cnt;
        rx_en = 1'b0;
        send_frame(8'h33, 1'b0, 1'b1, -1);
        wait_clk(30);
        checks++;
        if (tick_cnt - t0 !== 0) begin errors++; $display("FAIL rxen_off_ticks: got %0d expected 0", tick_cnt - t0); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL rxen_off_err: got %0d expected 0", err_cnt - e0); end
        // Enable dropped after data bit 2 must not disturb the frame in flight.
        rx_en = 1'b1;
        t0 = tick_cnt; e0 = err_cnt;
        send_frame(8'h99, 1'b0, 1'b1, 4);
        wait_clk(30);
        rx_en = 1'b1;
        checks++;
        if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL rxen_mid_ticks: got %0d expected 1", tick_cnt - t0); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL rxen_mid_err: got %0d expected 0", err_cnt - e0); end
        checks++;
        if (dout !== 8'h99) begin errors++; $display("FAIL rxen_mid_dout: got %h expected 99", dout); end
    endtask

    task automatic test_reset_mid;
        int t0, e0;
        logic [10:0] bits;
        bits = {1'b1, ~^8'hFF, 8'hFF, 1'b0};
        send_bits(bits, 6, -1);       // start + 5 data bits
        #3 reset = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout: got %h expected 00", dout); end
        checks++;
        if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL rstmid_tick: got %b expected 0", rx_done_tick); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 0", frame_err); end
        wait_clk(2);
        reset = 1'b1;
        ps2d = 1'b1;
        wait_clk(20);
        t0 = tick_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        wait_clk(30);
        checks++;
        if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL rstmid_ticks: got %0d expected 1", tick_cnt - t0); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL rstmid_err_after: got %0d expected 0", err_cnt - e0); end
        checks++;
        if (dout !== 8'h3C) begin errors++; $display("FAIL rstmid_dout_after: got %h expected 3c", dout); end
    endtask

    initial begin
        reset = 1'b0;
        rx_en = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        wait_clk(3);
        test_reset;
        reset = 1'b1;
        wait_clk(20);
        test_single;
        test_back_to_back;
        test_glitch;
        test_bad_stop;
        test_parity;
        test_timeout;
        test_rx_en;
        test_reset_mid;
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL tick_and_err_overlap: got %0d expected 0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 device-to-host receiver. Synchronises and deglitches the ps2c/ps2d lines, deserialises each 11-bit PS/2 frame (start, 8 data LSB-first, odd parity, stop) and presents one byte per frame with a single-cycle strobe. Sits directly upstream of the 4-byte packet buffer: dout drives the buffer's d and rx_done_tick drives its tick.

Parameters:
FILTER_LEN, 8, number of consecutive equal ps2c samples required to change the filtered clock level (valid range 2..16)
TIMEOUT_CYC, 5000, clk cycles allowed between falling edges inside a frame before it is aborted (100 us at 50 MHz)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-low (asserted when 0)
rx_en  input  1  receive enable; gates recognition of a start bit only
ps2c  input  1  raw PS/2 clock line (asynchronous to clk)
ps2d  input  1  raw PS/2 data line (asynchronous to clk)
dout  output  8  last correctly received byte
rx_done_tick  output  1  one-cycle pulse: dout holds a new byte
frame_err  output  1  one-cycle pulse: frame discarded

Behaviour:
- Reset (reset=0, async): FSM=IDLE, dout=8'h00, rx_done_tick=0, frame_err=0, filter register all ones, filtered clock=1, bit counter=0, timeout counter=0.
- Sync: ps2c and ps2d each pass through a 2-FF synchroniser before any use.
- Filter: FILTER_LEN-bit shift register of synced ps2c. Filtered level goes to 1 when all bits are 1, to 0 when all bits are 0, otherwise holds. fall = filtered_prev & ~filtered_now, lasts one cycle. ps2d is sampled in the same cycle that fall is high.
- FSM states IDLE, DPS, LOAD:
  - IDLE: on fall with rx_en=1: if ps2d=0, load bit count 10, clear timeout, go to DPS. If ps2d=1, pulse frame_err and stay in IDLE. A fall while rx_en=0 is ignored.
  - DPS: on each fall, shift ps2d into the MSB of a 10-bit shift register, decrement the count and clear the timeout. After the 10th shift, go to LOAD. With no fall, the timeout increments; at TIMEOUT_CYC-1, pulse frame_err and go to IDLE.
  - LOAD (one cycle): stop bit (shreg[9]) = 1 -> dout <= shreg[7:0] and rx_done_tick=1. Stop bit = 0 -> frame_err=1 and dout is unchanged. Always returns to IDLE.
- Latency: rx_done_tick rises 1 clk after the cycle in which the stop-bit fall is detected.
- rx_done_tick and frame_err are never high in the same cycle.
- dout holds its value between ticks.
- Deasserting rx_en mid-frame has no effect; the frame completes.
- Reset mid-frame discards the partial frame with no strobe. The first fall after reset release is treated as a start bit.
- Back-to-back frames: a fall in the LOAD cycle is not possible (the filter delay exceeds 1 cycle). A fall in IDLE immediately after LOAD is accepted.

Optional Feature:
PS2_RX_PARITY_EN
- Defined: in LOAD, odd parity over shreg[7:0] and shreg[8] is checked. On mismatch: frame_err=1, no rx_done_tick, dout unchanged. The stop-bit check still applies.
- Undefined: the parity bit is shifted in and ignored; no parity logic is synthesised.

Decomposition:
- Package ps2_pkg holds:
  - state typedef {IDLE, DPS, LOAD}
  - DATA_W=8
  - FRAME_SHIFT_BITS=10
  - PS2_PARITY_ODD=1
- One sub-module, ps2_clk_filter: 2-FF synchronisers, glitch filter and fall-edge detector. Outputs: fall, ps2d_s.

Test Plan:
- Frame 0x1C (parity 0, stop 1), ps2c half-period 40 clk -> dout=8'h1C, rx_done_tick high exactly 1 cycle, 1 clk after the stop-bit fall; frame_err stays 0.
- Four frames back-to-back: 0xF0, 0x1C, 0xE0, 0x75 -> four ticks in order, dout matches each. With the downstream buffer attached, data = 32'hF01CE075 and ready asserts.
- 3-cycle low glitch on ps2c in IDLE with FILTER_LEN=8 -> no state change, no strobes. Repeat with a 9-cycle low pulse -> start bit accepted.
- Frame 0x55 with stop bit 0 -> frame_err 1 cycle, no tick, dout keeps the previous value. With PS2_RX_PARITY_EN: frame 0x55 with parity 0 -> frame_err, no tick.
- TIMEOUT_CYC=200, stop ps2c after 4 data bits -> frame_err 200 cycles after the last fall, FSM back in IDLE; the next frame 0xA3 is received correctly.
- reset=0 for 2 cycles mid-frame (after bit 5) -> outputs return to reset values immediately. After release, a full frame 0x3C -> dout=8'h3C.
